// File: rtl/mult_pkg.sv
// -----------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the sequential multiply-accumulate datapath:
//   - state_t   : controller states (IDLE, CALC, FINISH)
//   - cnt_width : width of the multiplier-bit counter for a given operand width
// No ports (package).
// -----------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // Counter must index every multiplier bit 0..width-1.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
// One-bit full adder cell used to build the ripple-carry adder.
// Ports:
//   i_a, i_b  : addend bits
//   i_cin     : carry in
//   o_sum     : sum bit
//   o_cout    : carry out
// -----------------------------------------------------------------------------
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/rca_adder.sv
// -----------------------------------------------------------------------------
// rca_adder
// N-bit ripple-carry adder: {o_cout, o_sum} = i_a + i_b + i_cin.
// Ports:
//   o_sum   [N-1:0] : sum
//   o_cout          : carry out of the top bit
//   i_a     [N-1:0] : addend
//   i_b     [N-1:0] : addend
//   i_cin           : carry in (used for two's-complement negation)
// -----------------------------------------------------------------------------
module rca_adder #(
    parameter int N = 16
) (
    output logic [N-1:0] o_sum,
    output logic         o_cout,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin
);

    logic [N:0] w_carry;

    assign w_carry[0] = i_cin;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_fa
            full_adder u_fa (
                .i_a    (i_a[gi]),
                .i_b    (i_b[gi]),
                .i_cin  (w_carry[gi]),
                .o_sum  (o_sum[gi]),
                .o_cout (w_carry[gi+1])
            );
        end
    endgenerate

    assign o_cout = w_carry[N];

endmodule

// File: rtl/seq_mult_acc.sv
// -----------------------------------------------------------------------------
// seq_mult_acc
// Sequential shift-and-add multiplier with optional accumulate. Operands are
// WIDTH bits, unsigned or two's complement; the result is 2*WIDTH bits.
// Fixed latency of WIDTH+1 cycles from an accepted Load to Done.
// Ports:
//   Clk     : clock, rising edge
//   Reset   : synchronous, active-high reset (aborts any operation, clears O)
//   Load    : start request, sampled only while Ready=1
//   A, B    : multiplicand / multiplier, captured on accepted Load
//   Signed  : 1 = two's-complement operands, captured on accepted Load
//   Acc     : 1 = O <= O + product, 0 = O <= product, captured on accepted Load
//   O       : registered result, held between operations
//   Done    : one-cycle pulse when O updates
//   Ready   : high while idle
//   Ovf     : accumulate overflow, valid with Done and held until next Done
// -----------------------------------------------------------------------------
module seq_mult_acc
    import mult_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Load,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic               Signed,
    input  logic               Acc,
    output logic [2*WIDTH-1:0] O,
    output logic               Done,
    output logic               Ready,
    output logic               Ovf
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t          r_state;
    state_t          w_state_next;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic             r_neg;
    logic             r_acc;
    logic             r_signed;
    logic [PW-1:0]    r_partial;
    logic [CW-1:0]    r_cnt;
    logic [PW-1:0]    r_o;
    logic             r_done;
    logic             r_ovf;

    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_last;
    logic             w_mbit;
    logic [PW-1:0]    w_shifted;
    logic [PW-1:0]    w_add_a;
    logic [PW-1:0]    w_add_b;
    logic             w_add_cin;
    logic [PW-1:0]    w_sum;
    logic             w_cout;
    logic             w_p_msb;
    logic             w_ovf;

    // Magnitudes; -2^(WIDTH-1) negates to itself, which is the correct
    // unsigned magnitude, so no special case is needed.
    assign w_a_mag = (Signed && A[WIDTH-1]) ? ({WIDTH{1'b0}} - A) : A;
    assign w_b_mag = (Signed && B[WIDTH-1]) ? ({WIDTH{1'b0}} - B) : B;

    assign w_last    = (r_cnt == LAST_CNT);
    assign w_mbit    = r_mplier[r_cnt];
    assign w_shifted = {{WIDTH{1'b0}}, r_mcand} << r_cnt;

    // Single adder, time-shared between partial-product adds (CALC) and the
    // final negate / accumulate (FINISH).
    always_comb begin
        w_add_a   = r_partial;
        w_add_b   = '0;
        w_add_cin = 1'b0;
        case (r_state)
            ST_CALC: begin
                w_add_a = r_partial;
                w_add_b = w_mbit ? w_shifted : '0;
            end
            ST_FINISH: begin
                if (r_acc) begin
                    // For a negative product r_partial already holds ~|p|,
                    // so O + ~|p| + 1 = O - |p| in one pass.
                    w_add_a   = r_o;
                    w_add_b   = r_partial;
                    w_add_cin = r_neg;
                end else begin
                    w_add_a   = r_neg ? ~r_partial : r_partial;
                    w_add_b   = '0;
                    w_add_cin = r_neg;
                end
            end
            default: ;
        endcase
    end

    rca_adder #(
        .N (PW)
    ) u_adder (
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .i_a    (w_add_a),
        .i_b    (w_add_b),
        .i_cin  (w_add_cin)
    );

    // Sign of the accumulated product p. When negative, r_partial holds ~|p|;
    // p is negative unless |p| is zero (~|p| all ones).
    assign w_p_msb = r_neg ? (r_partial != {PW{1'b1}}) : r_partial[PW-1];

    always_comb begin
        w_ovf = 1'b0;
        if (r_acc) begin
            if (r_signed) begin
                w_ovf = (r_o[PW-1] == w_p_msb) && (w_sum[PW-1] != r_o[PW-1]);
            end else begin
                w_ovf = w_cout;
            end
        end
    end

    // Controller state register.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Controller next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (Load) w_state_next = ST_CALC;
            ST_CALC:   if (w_last) w_state_next = ST_FINISH;
            ST_FINISH: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_neg     <= 1'b0;
            r_acc     <= 1'b0;
            r_signed  <= 1'b0;
            r_partial <= '0;
            r_cnt     <= '0;
            r_o       <= '0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (Load) begin
                        r_mcand   <= w_a_mag;
                        r_mplier  <= w_b_mag;
                        r_neg     <= Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_acc     <= Acc;
                        r_signed  <= Signed;
                        r_partial <= '0;
                        r_cnt     <= '0;
                    end
                end
                ST_CALC: begin
                    r_cnt <= r_cnt + CW'(1);
                    // Pre-invert on the last step so an accumulate of a
                    // negative product needs only one add in FINISH.
                    r_partial <= (w_last && r_acc && r_neg) ? ~w_sum : w_sum;
                end
                ST_FINISH: begin
                    r_o    <= w_sum;
                    r_ovf  <= w_ovf;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign O     = r_o;
    assign Done  = r_done;
    assign Ovf   = r_ovf;
    assign Ready = (r_state == ST_IDLE);

endmodule

// File: tb/tb_seq_mult_acc.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_acc
// Scoreboard bench for seq_mult_acc (WIDTH=8). The driver pushes the expected
// result, overflow flag and Done cycle for each accepted operation; a monitor
// on the falling edge pops and compares whenever Done is high.
// -----------------------------------------------------------------------------
module tb_seq_mult_acc;

    localparam int W = 8;

    logic           Clk;
    logic           Reset;
    logic           Load;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic           Signed;
    logic           Acc;
    logic [2*W-1:0] O;
    logic           Done;
    logic           Ready;
    logic           Ovf;

    typedef struct {
        logic [2*W-1:0] o;
        logic           ovf;
        int             cyc;
        int             id;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int  cyc        = 0;
    int  n_checks   = 0;
    int  n_fail     = 0;
    int  end_wait   = 0;
    bit  prev_done  = 1'b0;
    bit  rst_probe  = 1'b0;
    bit  end_req    = 1'b0;

    seq_mult_acc #(
        .WIDTH (W)
    ) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Load   (Load),
        .A      (A),
        .B      (B),
        .Signed (Signed),
        .Acc    (Acc),
        .O      (O),
        .Done   (Done),
        .Ready  (Ready),
        .Ovf    (Ovf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Wait for Ready, present one operation, optionally record its expectation.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic ac,
                         input logic [2*W-1:0] eo, input logic eovf,
                         input bit push, input bit keep, input int id);
        int waited;
        waited = 0;
        @(negedge Clk);
        while (!Ready) begin
            if (waited > 40) begin
                $display("FAIL ready_timeout op %0d: Ready=%0b required 1", id, Ready);
                $fatal(1, "Ready never asserted");
            end
            waited++;
            @(negedge Clk);
        end
        A      = a;
        B      = b;
        Signed = s;
        Acc    = ac;
        Load   = 1'b1;
        if (push) sb.push_back('{o: eo, ovf: eovf, cyc: cyc + W + 2, id: id});
        if (!keep) begin
            @(negedge Clk);
            Load = 1'b0;
        end
    endtask

    // Ask the monitor to compare reset-state outputs on the next falling edge.
    task automatic probe_reset();
        @(posedge Clk);
        #1 rst_probe = 1'b1;
        @(posedge Clk);
        #1 rst_probe = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; Load = 1'b0; A = '0; B = '0; Signed = 1'b0; Acc = 1'b0;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        probe_reset();

        // Unsigned, replace mode and accumulate.
        issue(8'd10,  8'd10,  1'b0, 1'b0, 16'd100,   1'b0, 1'b1, 1'b0, 1);
        issue(8'd200, 8'd200, 1'b0, 1'b1, 16'd40100, 1'b0, 1'b1, 1'b0, 2);
        issue(8'd255, 8'd255, 1'b0, 1'b0, 16'd65025, 1'b0, 1'b1, 1'b0, 3);
        issue(8'd255, 8'd255, 1'b0, 1'b1, 16'd64514, 1'b1, 1'b1, 1'b0, 4);
        issue(8'd0,   8'd200, 1'b0, 1'b0, 16'd0,     1'b0, 1'b1, 1'b0, 5);

        // Signed products.
        issue(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, 1'b0, 1'b1, 1'b0, 6);
        issue(8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 1'b0, 1'b1, 1'b0, 7);
        issue(8'h7F, 8'hFF, 1'b1, 1'b0, 16'hFF81, 1'b0, 1'b1, 1'b0, 8);

        // Signed accumulate: negative addend, growth to overflow, zero product.
        issue(8'hFD, 8'h05, 1'b1, 1'b1, 16'hFF72, 1'b0, 1'b1, 1'b0, 9);
        issue(8'h7F, 8'h7F, 1'b1, 1'b0, 16'h3F01, 1'b0, 1'b1, 1'b0, 10);
        issue(8'h80, 8'h80, 1'b1, 1'b1, 16'h7F01, 1'b0, 1'b1, 1'b0, 11);
        issue(8'h7F, 8'h7F, 1'b1, 1'b1, 16'hBE02, 1'b1, 1'b1, 1'b0, 12);
        issue(8'h00, 8'hFB, 1'b1, 1'b1, 16'hBE02, 1'b0, 1'b1, 1'b0, 13);

        // Load pulsed during CALC with other operands is ignored.
        issue(8'd3, 8'd4, 1'b0, 1'b0, 16'd12, 1'b0, 1'b1, 1'b0, 14);
        repeat (2) @(negedge Clk);
        A = 8'd7; B = 8'd9; Load = 1'b1;
        @(negedge Clk);
        Load = 1'b0;

        // Load held high: next operation starts in the Done cycle.
        issue(8'd5, 8'd6, 1'b0, 1'b0, 16'd30, 1'b0, 1'b1, 1'b1, 15);
        issue(8'd2, 8'd3, 1'b0, 1'b1, 16'd36, 1'b0, 1'b1, 1'b0, 16);

        // Reset four cycles into an operation: aborted, no Done, O cleared.
        issue(8'd9, 8'd9, 1'b0, 1'b0, 16'd81, 1'b0, 1'b0, 1'b0, 17);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk);
        #1 rst_probe = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        @(posedge Clk);
        #1 rst_probe = 1'b0;

        // Accumulate onto the post-reset zero.
        issue(8'd11, 8'd11, 1'b0, 1'b1, 16'd121, 1'b0, 1'b1, 1'b0, 18);

        end_req = 1'b1;
    end

    always @(negedge Clk) begin
        if (rst_probe) begin
            n_checks++;
            if (O !== '0) begin
                n_fail++;
                $display("FAIL reset_o: got %h required 0000", O);
            end
            n_checks++;
            if (Done !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_done: got %b required 0", Done);
            end
            n_checks++;
            if (Ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_ready: got %b required 1", Ready);
            end
            n_checks++;
            if (Ovf !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_ovf: got %b required 0", Ovf);
            end
        end

        if (Done === 1'b1) begin
            n_checks++;
            if (prev_done) begin
                n_fail++;
                $display("FAIL done_pulse: Done high %0d cycles in a row, required 1", 2);
            end
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got Done with O=%h, required no Done", O);
            end else begin
                e = sb.pop_front();
                $display("op %0d: O=%h Ovf=%b at cycle %0d (expected O=%h Ovf=%b cycle %0d)",
                         e.id, O, Ovf, cyc, e.o, e.ovf, e.cyc);
                n_checks++;
                if (O !== e.o) begin
                    n_fail++;
                    $display("FAIL op%0d_result: got %h required %h", e.id, O, e.o);
                end
                n_checks++;
                if (Ovf !== e.ovf) begin
                    n_fail++;
                    $display("FAIL op%0d_ovf: got %b required %b", e.id, Ovf, e.ovf);
                end
                n_checks++;
                if (cyc != e.cyc) begin
                    n_fail++;
                    $display("FAIL op%0d_latency: Done at cycle %0d required %0d", e.id, cyc, e.cyc);
                end
            end
        end
        prev_done = (Done === 1'b1);

        if (end_req) begin
            end_wait++;
            if (sb.size() == 0 && end_wait > 15) begin
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end else if (end_wait > 60) begin
                n_checks++;
                n_fail++;
                $display("FAIL drain: %0d results still pending, required 0", sb.size());
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

endmodule
